// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-ramp controller and its period tick.
// step_toward moves a duty value one clamped step toward a target, never overshooting.
package pwm_pkg;

    localparam int PWM_W = 8;
    localparam logic [PWM_W-1:0] PERIOD_LAST = 8'hFF;

    typedef enum logic {IDLE, RAMP} ramp_state_t;

    // A 9-bit difference keeps the comparison free of wrap at both ends of the range.
    function automatic logic [PWM_W-1:0] step_toward(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] tgt,
        input logic [PWM_W-1:0] step
    );
        logic [PWM_W:0] d;
        if (tgt >= cur) begin
            d = {1'b0, tgt} - {1'b0, cur};
        end else begin
            d = {1'b0, cur} - {1'b0, tgt};
        end
        if (d <= {1'b0, step}) begin
            return tgt;
        end else if (tgt > cur) begin
            return cur + step;
        end else begin
            return cur - step;
        end
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running 8-bit phase counter kept in lock with the PWM generator counter.
// tick marks the last clock of each 256-clock PWM period.
module pwm_period_tick
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [PWM_W-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign tick = (phase == PERIOD_LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer: accepts a target duty and slews the PWM duty toward it,
// one fixed step every PERIODS_PER_STEP periods, only on period boundaries.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int               STEP             = 4,
    parameter int               PERIODS_PER_STEP = 2,
    parameter logic [PWM_W-1:0] INIT_DUTY        = 8'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] tgt_duty,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             abort,
    output logic [PWM_W-1:0] duty,
    output logic             busy,
    output logic             done
);

    localparam logic [PWM_W-1:0] STEP_V   = PWM_W'(STEP);
    localparam logic [7:0]       DIV_LAST = 8'(PERIODS_PER_STEP - 1);

    ramp_state_t      state;
    logic [PWM_W-1:0] tgt_q;
    logic [7:0]       div;
    logic             tick;
    logic [PWM_W-1:0] step_duty;

    pwm_period_tick u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        step_duty = step_toward(duty, tgt_q, STEP_V);
    end

    // Abort is checked before the tick so it wins over a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty      <= INIT_DUTY;
            tgt_q     <= INIT_DUTY;
            div       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tgt_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        tgt_q <= tgt_duty;
                        div   <= '0;
                        if (tgt_duty == duty) begin
                            done <= 1'b1;
                        end else begin
                            state     <= RAMP;
                            busy      <= 1'b1;
                            tgt_ready <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        tgt_ready <= 1'b1;
                        done      <= 1'b1;
                    end else if (tick) begin
                        if (div == DIV_LAST) begin
                            div  <= '0;
                            duty <= step_duty;
                            if (step_duty == tgt_q) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                tgt_ready <= 1'b1;
                                done      <= 1'b1;
                            end
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp with a behavioural PWM generator alongside it.
// The driver predicts every duty/done event with its clock edge; a monitor pops and compares.
module tb_pwm_duty_ramp;
    import pwm_pkg::*;

    localparam int         STEP = 4;
    localparam int         PPS  = 2;
    localparam logic [7:0] INIT = 8'd0;
    localparam int         BUDGET = 20000;

    logic       clk;
    logic       rst_n;
    logic [7:0] tgt_duty;
    logic       tgt_valid;
    logic       tgt_ready;
    logic       abort;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    typedef struct {
        int         edge_idx;
        logic [7:0] duty;
        logic       done;
    } ev_t;

    ev_t        exp_q[$];
    int         checks;
    int         errors;
    int         cyc;
    logic [7:0] plan_duty;
    logic [7:0] shown_duty;
    logic [7:0] pwm_cnt;
    logic       pwm_out;

    pwm_duty_ramp #(
        .STEP            (STEP),
        .PERIODS_PER_STEP(PPS),
        .INIT_DUTY       (INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt_duty (tgt_duty),
        .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready),
        .abort    (abort),
        .duty     (duty),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PWM generator sharing the reset net; cyc numbers clock edges since release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'd0;
            cyc     <= 0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            cyc     <= cyc + 1;
        end
    end

    assign pwm_out = (pwm_cnt <= duty);

    function automatic logic [7:0] refStep(input logic [7:0] cur, input logic [7:0] tgt);
        int diff;
        diff = int'(tgt) - int'(cur);
        if (diff > STEP) return 8'(int'(cur) + STEP);
        if (diff < -STEP) return 8'(int'(cur) - STEP);
        return tgt;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tgt, input int abort_step);
        int         k_a;
        int         t1;
        int         edge_i;
        int         abort_edge;
        int         n;
        logic [7:0] cur;
        logic [7:0] start;
        @(negedge clk);
        checkOutput("tgt_ready_idle", int'(tgt_ready), 1);
        tgt_duty   = tgt;
        tgt_valid  = 1'b1;
        k_a        = cyc;
        start      = plan_duty;
        cur        = plan_duty;
        abort_edge = -1;
        if (tgt == cur) begin
            exp_q.push_back('{k_a, cur, 1'b1});
        end else begin
            t1 = (k_a / 256) * 256 + 255;
            if (t1 <= k_a) t1 += 256;
            n = 0;
            while (cur != tgt) begin
                n++;
                edge_i = t1 + (n * PPS - 1) * 256;
                if (n == abort_step) begin
                    abort_edge = edge_i;
                    exp_q.push_back('{edge_i, cur, 1'b1});
                    break;
                end
                cur = refStep(cur, tgt);
                exp_q.push_back('{edge_i, cur, cur == tgt});
            end
        end
        plan_duty = cur;
        @(negedge clk);
        tgt_valid = 1'b0;
        checkOutput("busy_after_accept", int'(busy), (tgt != start) ? 1 : 0);
        if (abort_edge >= 0) begin
            for (int i = 0; i < BUDGET && cyc != abort_edge; i++) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < BUDGET && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: any duty change or done pulse must match the head of the scoreboard.
    initial begin
        logic [7:0] prev_duty;
        logic       per_valid;
        int         hi_cnt;
        int         per_exp;
        ev_t        ev;
        prev_duty = INIT;
        per_valid = 1'b0;
        hi_cnt    = 0;
        per_exp   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_duty  = INIT;
                shown_duty = INIT;
                per_valid  = 1'b0;
            end else begin
                if (duty !== prev_duty || done === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_event: edge %0d duty %0d done %0b busy %0b",
                                 cyc - 1, duty, done, busy);
                    end else begin
                        ev = exp_q.pop_front();
                        if (cyc - 1 != ev.edge_idx || duty !== ev.duty || done !== ev.done ||
                            busy !== !ev.done) begin
                            errors++;
                            $display("[TB] FAIL event: got edge %0d duty %0d done %0b busy %0b expected edge %0d duty %0d done %0b busy %0b",
                                     cyc - 1, duty, done, busy, ev.edge_idx, ev.duty, ev.done, !ev.done);
                        end
                        shown_duty = ev.duty;
                    end
                end
                prev_duty = duty;
                if (pwm_cnt == 8'd0) begin
                    per_valid = 1'b1;
                    hi_cnt    = 0;
                    per_exp   = int'(shown_duty) + 1;
                end
                if (per_valid) begin
                    if (pwm_out) hi_cnt++;
                    if (pwm_cnt == 8'hFF) checkOutput("pwm_high_width", hi_cnt, per_exp);
                end
            end
        end
    end

    initial begin
        int t;
        int ab;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        tgt_duty   = 8'd0;
        tgt_valid  = 1'b0;
        abort      = 1'b0;
        plan_duty  = INIT;
        shown_duty = INIT;

        #12;
        checkOutput("reset_duty", int'(duty), int'(INIT));
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_tgt_ready", int'(tgt_ready), 1);
        #10 rst_n = 1'b1;

        $display("[TB] ramp 0 -> 16");
        repeat (9) @(negedge clk);
        applyStimulus(8'd16, 0);
        waitDrain("ramp_up");

        $display("[TB] target equal to current duty");
        applyStimulus(8'd16, 0);
        waitDrain("equal_target");
        checkOutput("equal_duty", int'(duty), 16);

        $display("[TB] ramp 16 -> 3 with clamped last step");
        applyStimulus(8'd3, 0);
        waitDrain("ramp_down");

        $display("[TB] request during ramp is ignored");
        applyStimulus(8'd11, 0);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_duty  = 8'd200;
        checkOutput("ready_low_in_ramp", int'(tgt_ready), 0);
        repeat (300) @(negedge clk);
        checkOutput("ready_low_late_ramp", int'(tgt_ready), 0);
        tgt_valid = 1'b0;
        waitDrain("ignored_request");
        checkOutput("ignored_final_duty", int'(duty), 11);

        $display("[TB] abort on a step tick");
        applyStimulus(8'd0, 0);
        waitDrain("ramp_to_zero");
        applyStimulus(8'd16, 3);
        waitDrain("abort");
        checkOutput("abort_duty", int'(duty), 8);
        checkOutput("abort_ready", int'(tgt_ready), 1);

        $display("[TB] reset mid-ramp");
        applyStimulus(8'd24, 0);
        for (int i = 0; i < BUDGET && exp_q.size() > 3; i++) @(negedge clk);
        checkOutput("pre_reset_duty", int'(duty), 12);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_duty", int'(duty), int'(INIT));
        checkOutput("async_reset_busy", int'(busy), 0);
        checkOutput("async_reset_ready", int'(tgt_ready), 1);
        exp_q.delete();
        plan_duty = INIT;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(8'd8, 0);
        waitDrain("post_reset_ramp");

        $display("[TB] randomized targets");
        for (int r = 0; r < 5; r++) begin
            t = int'(plan_duty) + int'($urandom_range(0, 48)) - 24;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(8'(t), ab);
            waitDrain("random_ramp");
            repeat (int'($urandom_range(0, 300))) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
